// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: valid/ready operand intake, FSM-driven execute, held result port.
// Optional feature macro: ALU_SHIFT_EN (adds iterative SLL/SRL, one bit per cycle).
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
`endif

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0 || SHAMT_W != $clog2(WIDTH)) begin : g_bad_width
    $error("alu_exec_unit: WIDTH must be a power of two >= 8 and SHAMT_W must stay derived");
  end

  state_t           state, state_next;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;   // doubles as the shift working register
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_res;
  logic             legal;
  logic             exec_done;
`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] cnt_q;
  logic               is_shift;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = EXEC;
      EXEC:    if (exec_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    unique case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_ADD: alu_res = a_q + b_q;
      OP_SUB: alu_res = a_q - b_q;
`ifdef ALU_SHIFT_EN
      OP_SLL, OP_SRL: alu_res = a_q;
`endif
      default: legal = 1'b0;
    endcase
  end

`ifdef ALU_SHIFT_EN
  always_comb begin
    is_shift  = (op_q == OP_SLL) || (op_q == OP_SRL);
    exec_done = !(is_shift && cnt_q != '0);
  end
`else
  always_comb exec_done = 1'b1;
`endif

  // NOTE: operand/result registers are few and externally visible, so they are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_SHIFT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q  <= operation;
          a_q   <= a;
          b_q   <= b;
`ifdef ALU_SHIFT_EN
          cnt_q <= b[SHAMT_W-1:0];
`endif
        end
        EXEC: if (exec_done) begin
          result  <= alu_res;
          zero    <= (alu_res == '0);
          illegal <= !legal;
        end
`ifdef ALU_SHIFT_EN
        else begin
          a_q   <= (op_q == OP_SLL) ? (a_q << 1) : (a_q >> 1);
          cnt_q <= cnt_q - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
